// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: load-size encodings,
// major opcodes and the memory FSM state type.
package mem_pkg;

  localparam logic [1:0] LDSZ_BYTE = 2'b00;
  localparam logic [1:0] LDSZ_HALF = 2'b01;
  localparam logic [1:0] LDSZ_WORD = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/ld_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it to 32 bits.
module ld_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ldsz,
  input  logic [1:0]  ldshift,
  input  logic        ld_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {ldshift, 3'b000});
    half_sel = 16'(rdata >> {ldshift[1], 4'b0000});
    case (ldsz)
      LDSZ_BYTE: result = {{24{byte_sel[7] & ~ld_unsigned}}, byte_sel};
      LDSZ_HALF: result = {{16{half_sel[15] & ~ld_unsigned}}, half_sel};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX result, runs loads/stores
// over a req/gnt/rvalid port and feeds rd_MEM/res_MEM back for forwarding.
module mem_stage
  import mem_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_PC_Z = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_stall,
  input  logic            valid_EX,
  input  logic [6:0]      opcode_EX,
  input  logic [4:0]      rd_EX,
  input  logic [XLEN-1:0] res_EX,
  input  logic [XLEN-1:0] x2_EX,
  input  logic [1:0]      ldsz,
  input  logic [1:0]      ldshift,
  input  logic            ld_unsigned,
  input  logic            trap_EX,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      rd_MEM,
  output logic [XLEN-1:0] res_MEM,
  output logic            valid_MEM,
  output logic            stall_req,
  output logic            trap_MEM
);

  // Handshake: a request is transferred on a cycle where dmem_req && dmem_gnt;
  // req and its address/we/be/wdata hold steady until then. Load data arrives
  // on a later cycle with dmem_rvalid, which is only honoured in WAIT.

  mem_state_e state, state_next;

  logic            valid_q, trap_q, ld_unsigned_q;
  logic [6:0]      opcode_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] res_q, x2_q;
  logic [1:0]      ldsz_q, ldshift_q;

  logic            capture, is_store_q, is_mem_EX;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata, ld_data;

  assign capture    = !ext_stall && !stall_req;
  assign is_store_q = (opcode_q == OP_STORE);
  assign is_mem_EX  = (opcode_EX == OP_LOAD) || (opcode_EX == OP_STORE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (capture && valid_EX && !trap_EX && is_mem_EX) state_next = REQ;
      REQ:  if (dmem_gnt) state_next = is_store_q ? IDLE : WAIT;
      WAIT: if (dmem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (ldsz_q)
      LDSZ_BYTE: begin
        lane_be    = 4'b0001 << ldshift_q;
        lane_wdata = {4{x2_q[7:0]}};
      end
      LDSZ_HALF: begin
        lane_be    = 4'b0011 << {ldshift_q[1], 1'b0};
        lane_wdata = {2{x2_q[15:0]}};
      end
      default: begin
        lane_be    = 4'hF;
        lane_wdata = x2_q;
      end
    endcase

    stall_req  = (state != IDLE);
    dmem_req   = (state == REQ);
    dmem_we    = dmem_req && is_store_q;
    dmem_be    = dmem_req ? lane_be : 4'h0;
    dmem_addr  = dmem_req ? res_q : '0;
    dmem_wdata = dmem_req ? lane_wdata : '0;

    rd_MEM     = (valid_q && !trap_q && opcode_q != OP_STORE && opcode_q != OP_BRANCH)
                 ? rd_q : 5'd0;
    res_MEM    = res_q;
    valid_MEM  = valid_q && (state == IDLE);
    trap_MEM   = valid_q && trap_q;
  end

  // Capture only happens in IDLE, so it never collides with the WAIT writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      trap_q        <= 1'b0;
      ld_unsigned_q <= 1'b0;
      opcode_q      <= 7'd0;
      rd_q          <= 5'd0;
      res_q         <= RST_PC_Z;
      x2_q          <= '0;
      ldsz_q        <= 2'd0;
      ldshift_q     <= 2'd0;
    end else if (capture) begin
      valid_q       <= valid_EX;
      trap_q        <= trap_EX;
      ld_unsigned_q <= ld_unsigned;
      opcode_q      <= opcode_EX;
      rd_q          <= rd_EX;
      res_q         <= res_EX;
      x2_q          <= x2_EX;
      ldsz_q        <= ldsz;
      ldshift_q     <= ldshift;
    end else if (state == WAIT && dmem_rvalid) begin
      res_q         <= ld_data;
    end
  end

  ld_align u_ld_align (
    .rdata       (dmem_rdata),
    .ldsz        (ldsz_q),
    .ldshift     (ldshift_q),
    .ld_unsigned (ld_unsigned_q),
    .result      (ld_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads/stores/ALU streams checked against a small arithmetic model.
module tb_mem_stage;

  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_stall, valid_ex, ld_unsigned, trap_ex;
  logic [6:0]  opcode_ex;
  logic [4:0]  rd_ex;
  logic [31:0] res_ex, x2_ex;
  logic [1:0]  ldsz, ldshift;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  rd_mem;
  logic [31:0] res_mem;
  logic        valid_mem, stall_req, trap_mem;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  int          obs_stall, obs_req_cycles, obs_dup;
  logic        obs_unstable, obs_timeout, obs_seen, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .valid_EX(valid_ex), .opcode_EX(opcode_ex), .rd_EX(rd_ex),
    .res_EX(res_ex), .x2_EX(x2_ex), .ldsz(ldsz), .ldshift(ldshift),
    .ld_unsigned(ld_unsigned), .trap_EX(trap_ex),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rd_MEM(rd_mem), .res_MEM(res_mem), .valid_MEM(valid_mem),
    .stall_req(stall_req), .trap_MEM(trap_mem)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] sz, logic [1:0] sh,
                                             logic uns);
    int unsigned v;
    case (sz)
      2'b00: begin
        v = (w >> (8 * sh)) & 32'hFF;
        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end
      2'b01: begin
        v = (w >> (16 * (sh / 2))) & 32'hFFFF;
        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] sz, logic [1:0] sh);
    int b;
    case (sz)
      2'b00:   b = 1 << sh;
      2'b01:   b = 3 << (sh & 2'b10);
      default: b = 15;
    endcase
    return b[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] x);
    case (sz)
      2'b00:   return (x & 32'hFF) * 32'h01010101;
      2'b01:   return (x & 32'hFFFF) * 32'h00010001;
      default: return x;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    valid_ex = 0; opcode_ex = OPC_ALU; rd_ex = 0; res_ex = 0; x2_ex = 0;
    ldsz = 2'b11; ldshift = 0; ld_unsigned = 0; trap_ex = 0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] x2, input logic [1:0] sz, input logic [1:0] sh,
                       input logic uns, input logic trap);
    valid_ex = 1; opcode_ex = op; rd_ex = rd; res_ex = res; x2_ex = x2;
    ldsz = sz; ldshift = sh; ld_unsigned = uns; trap_ex = trap;
  endtask

  // Captures the driven instruction, then plays the memory side until the stage
  // leaves its busy state, recording what the request looked like.
  task automatic mem_txn(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input logic noise);
    int   cyc, since;
    logic granted, req_pre;
    tick;
    bubble;
    obs_stall = 0; obs_req_cycles = 0; obs_dup = 0; obs_unstable = 0; obs_timeout = 0;
    obs_seen = 0; granted = 0; since = 0; cyc = 0;
    while (stall_req && !obs_timeout) begin
      obs_stall++;
      req_pre = dmem_req;
      if (!granted) begin
        if (dmem_req) begin
          obs_req_cycles++;
          if (!obs_seen) begin
            obs_seen = 1; obs_addr = dmem_addr; obs_be = dmem_be;
            obs_wdata = dmem_wdata; obs_we = dmem_we;
          end else if (dmem_addr !== obs_addr || dmem_be !== obs_be ||
                       dmem_wdata !== obs_wdata || dmem_we !== obs_we) begin
            obs_unstable = 1;
          end
        end
        dmem_gnt    = (since >= gnt_dly);
        dmem_rvalid = noise && ($urandom_range(0, 1) == 1);
        dmem_rdata  = $urandom;
      end else begin
        if (dmem_req) obs_dup++;
        dmem_gnt    = 0;
        dmem_rvalid = (since >= rv_dly);
        dmem_rdata  = dmem_rvalid ? rdata : $urandom;
      end
      ext_stall = noise && ($urandom_range(0, 1) == 1);
      tick;
      if (!granted && dmem_gnt && req_pre) begin
        granted = 1;
        since = 0;
      end else begin
        since++;
      end
      cyc++;
      if (cyc > 60) obs_timeout = 1;
    end
    dmem_gnt = 0; dmem_rvalid = 0; ext_stall = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1; ext_stall = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    bubble;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, rd_mem, res_mem,
         valid_mem, stall_req, trap_mem} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b be=%h addr=%h res=%h rd=%0d valid=%b stall=%b trap=%b, want all 0",
               dmem_req, dmem_be, dmem_addr, res_mem, rd_mem, valid_mem, stall_req, trap_mem);
    end
    tick; tick;
    reset = 0;
    tick;
    n_checks++;
    if ({dmem_req, rd_mem, res_mem, valid_mem, stall_req, trap_mem} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got req=%b res=%h rd=%0d valid=%b stall=%b trap=%b, want all 0",
               dmem_req, res_mem, rd_mem, valid_mem, stall_req, trap_mem);
    end
  endtask

  task automatic test_alu;
    drive(OPC_ALU, 5'd5, 32'h42, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0);
    tick;
    bubble;
    n_checks++;
    if (rd_mem !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d want 5", rd_mem); end
    n_checks++;
    if (res_mem !== 32'h42) begin n_fail++; $display("FAIL alu_res: got %h want 00000042", res_mem); end
    n_checks++;
    if (valid_mem !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b want 1", valid_mem); end
    n_checks++;
    if (stall_req !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL alu_no_stall: got stall=%b req=%b want 0 0", stall_req, dmem_req);
    end
    tick;
  endtask

  task automatic test_load_word;
    drive(OPC_LOAD, 5'd7, 32'h100, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0);
    mem_txn(0, 0, 32'hDEADBEEF, 1'b0);
    n_checks++;
    if (obs_timeout || obs_stall != 2) begin
      n_fail++; $display("FAIL lw_stall_cycles: got %0d (timeout=%b) want 2", obs_stall, obs_timeout);
    end
    n_checks++;
    if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_be !== 4'hF) begin
      n_fail++; $display("FAIL lw_request: got addr=%h we=%b be=%h want 00000100 0 f", obs_addr, obs_we, obs_be);
    end
    n_checks++;
    if (res_mem !== 32'hDEADBEEF || valid_mem !== 1'b1 || rd_mem !== 5'd7) begin
      n_fail++; $display("FAIL lw_result: got res=%h valid=%b rd=%0d want deadbeef 1 7", res_mem, valid_mem, rd_mem);
    end
    tick;
  endtask

  task automatic test_load_align;
    logic [1:0]  d_sz[3]   = '{2'b00, 2'b00, 2'b01};
    logic [1:0]  d_sh[3]   = '{2'd3, 2'd3, 2'd2};
    logic        d_uns[3]  = '{1'b0, 1'b1, 1'b0};
    logic [31:0] d_want[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    logic [31:0] w, got;
    logic [1:0]  sz, sh;
    logic        uns;
    logic [4:0]  rd;
    for (int i = 0; i < 3; i++) begin
      drive(OPC_LOAD, 5'd4, 32'h200, 32'h0, d_sz[i], d_sh[i], d_uns[i], 1'b0);
      mem_txn(0, 0, (i == 2) ? 32'h80010000 : 32'h80000000, 1'b0);
      n_checks++;
      if (res_mem !== d_want[i]) begin
        n_fail++; $display("FAIL ld_directed_%0d: got %h want %h", i, res_mem, d_want[i]);
      end
      tick;
    end
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0:       begin sz = 2'b00; sh = 2'($urandom_range(0, 3)); end
        1:       begin sz = 2'b01; sh = 2'($urandom_range(0, 1) * 2); end
        default: begin sz = 2'b11; sh = 2'b00; end
      endcase
      uns = ($urandom_range(0, 1) == 1);
      w   = $urandom;
      rd  = 5'($urandom_range(1, 31));
      exp_q.push_back(model_load(w, sz, sh, uns));
      drive(OPC_LOAD, rd, {$urandom_range(0, 255), 2'b00}, $urandom, sz, sh, uns, 1'b0);
      mem_txn($urandom_range(0, 2), $urandom_range(0, 2), w, 1'b1);
      got = exp_q.pop_front();
      n_checks++;
      if (obs_timeout || res_mem !== got || rd_mem !== rd || valid_mem !== 1'b1) begin
        n_fail++;
        $display("FAIL ld_rand_%0d: got res=%h rd=%0d valid=%b want res=%h rd=%0d valid=1 (sz=%b sh=%0d uns=%b w=%h)",
                 i, res_mem, rd_mem, valid_mem, got, rd, sz, sh, uns, w);
      end
      tick;
    end
  endtask

  task automatic test_store;
    logic [1:0]  sz, sh;
    logic [31:0] x2, addr;
    drive(OPC_STORE, 5'd9, 32'h300, 32'h12345678, 2'b00, 2'd1, 1'b0, 1'b0);
    mem_txn(0, 0, 32'h0, 1'b0);
    n_checks++;
    if (obs_be !== 4'b0010 || obs_wdata !== 32'h78787878 || obs_we !== 1'b1) begin
      n_fail++; $display("FAIL sb_lanes: got be=%b wdata=%h we=%b want 0010 78787878 1", obs_be, obs_wdata, obs_we);
    end
    n_checks++;
    if (obs_timeout || obs_stall != 1 || rd_mem !== 5'd0 || valid_mem !== 1'b1) begin
      n_fail++; $display("FAIL sb_complete: got stall_cycles=%0d rd=%0d valid=%b want 1 0 1", obs_stall, rd_mem, valid_mem);
    end
    tick;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0:       begin sz = 2'b00; sh = 2'($urandom_range(0, 3)); end
        1:       begin sz = 2'b01; sh = 2'($urandom_range(0, 1) * 2); end
        default: begin sz = 2'b11; sh = 2'b00; end
      endcase
      x2 = $urandom;
      addr = {$urandom_range(0, 1023), 2'b00};
      drive(OPC_STORE, 5'($urandom_range(1, 31)), addr, x2, sz, sh, 1'b0, 1'b0);
      mem_txn($urandom_range(0, 3), 0, 32'h0, 1'b1);
      n_checks++;
      if (obs_timeout || obs_be !== model_be(sz, sh) || obs_wdata !== model_wdata(sz, x2) ||
          obs_addr !== addr || obs_we !== 1'b1 || obs_unstable || rd_mem !== 5'd0) begin
        n_fail++;
        $display("FAIL st_rand_%0d: got be=%b wdata=%h addr=%h we=%b unstable=%b rd=%0d want be=%b wdata=%h addr=%h we=1 unstable=0 rd=0",
                 i, obs_be, obs_wdata, obs_addr, obs_we, obs_unstable, rd_mem,
                 model_be(sz, sh), model_wdata(sz, x2), addr);
      end
      tick;
    end
  endtask

  task automatic test_gnt_delay;
    drive(OPC_LOAD, 5'd12, 32'h400, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0);
    mem_txn(3, 1, 32'h0BADF00D, 1'b1);
    n_checks++;
    if (obs_unstable || obs_req_cycles != 4) begin
      n_fail++; $display("FAIL gnt_delay_req: got unstable=%b req_cycles=%0d want 0 4", obs_unstable, obs_req_cycles);
    end
    n_checks++;
    if (obs_dup != 0 || obs_timeout || obs_stall != 6) begin
      n_fail++; $display("FAIL gnt_delay_stall: got dup=%0d stall_cycles=%0d timeout=%b want 0 6 0", obs_dup, obs_stall, obs_timeout);
    end
    n_checks++;
    if (res_mem !== 32'h0BADF00D || rd_mem !== 5'd12) begin
      n_fail++; $display("FAIL gnt_delay_data: got res=%h rd=%0d want 0badf00d 12", res_mem, rd_mem);
    end
    tick;
  endtask

  task automatic test_trap;
    drive(OPC_LOAD, 5'd9, 32'h104, 32'h0, 2'b11, 2'b00, 1'b0, 1'b1);
    tick;
    bubble;
    n_checks++;
    if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin
      n_fail++; $display("FAIL trap_no_req: got req=%b stall=%b want 0 0", dmem_req, stall_req);
    end
    n_checks++;
    if (trap_mem !== 1'b1 || rd_mem !== 5'd0) begin
      n_fail++; $display("FAIL trap_flag: got trap=%b rd=%0d want 1 0", trap_mem, rd_mem);
    end
    tick;
    n_checks++;
    if (trap_mem !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL trap_one_cycle: got trap=%b req=%b want 0 0", trap_mem, dmem_req);
    end
  endtask

  task automatic test_reset_in_wait;
    drive(OPC_LOAD, 5'd3, 32'h200, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0);
    tick;
    bubble;
    dmem_gnt = 1;
    tick;
    dmem_gnt = 0;
    n_checks++;
    if (stall_req !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL wait_state: got stall=%b req=%b want 1 0", stall_req, dmem_req);
    end
    reset = 1;
    #1;
    n_checks++;
    if ({dmem_req, dmem_be, dmem_addr, rd_mem, res_mem, valid_mem, stall_req, trap_mem} !== '0) begin
      n_fail++; $display("FAIL reset_in_wait: got req=%b res=%h rd=%0d valid=%b stall=%b want all 0",
                         dmem_req, res_mem, rd_mem, valid_mem, stall_req);
    end
    tick;
    reset = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    tick;
    dmem_rvalid = 0;
    n_checks++;
    if (stall_req !== 1'b0 || res_mem !== 32'h0 || valid_mem !== 1'b0) begin
      n_fail++; $display("FAIL stray_rvalid: got stall=%b res=%h valid=%b want 0 00000000 0", stall_req, res_mem, valid_mem);
    end
  endtask

  task automatic test_back_to_back;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    logic [6:0]  op;
    logic        v, stall;
    logic [4:0]  rd;
    logic [31:0] res;
    bubble;
    tick;
    e_valid = 0; e_rd = 0; e_res = 0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       op = OPC_ALU;
        1:       op = OPC_IMM;
        default: op = OPC_BRANCH;
      endcase
      v = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      rd = 5'($urandom_range(0, 31));
      res = $urandom;
      drive(op, rd, res, $urandom, 2'b11, 2'b00, 1'b0, 1'b0);
      valid_ex = v;
      ext_stall = stall;
      tick;
      if (!stall) begin
        e_valid = v;
        e_rd = (v && op != OPC_BRANCH) ? rd : 5'd0;
        e_res = res;
      end
      n_checks++;
      if (res_mem !== e_res || rd_mem !== e_rd || valid_mem !== e_valid || stall_req !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d: got res=%h rd=%0d valid=%b stall=%b want res=%h rd=%0d valid=%b stall=0",
                 i, res_mem, rd_mem, valid_mem, stall_req, e_res, e_rd, e_valid);
      end
    end
    ext_stall = 0;
    bubble;
    tick;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_word();
    test_load_align();
    test_store();
    test_gnt_delay();
    test_trap();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
